// File: rtl/ext_pipe_if.sv
// Handshake bundle between the extension unit and its producer/consumer.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready carry the valid-ready flow control on each side.
interface ext_pipe_if #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int TAG_W  = 5
);
   localparam int ADDR_W = $clog2(DATA_W / 8);

   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_op;
   logic [IMM_W-1:0]  in_imm;
   logic [DATA_W-1:0] in_data;
   logic [ADDR_W-1:0] in_addr;
   logic [TAG_W-1:0]  in_tag;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [TAG_W-1:0]  out_tag;
   logic              out_misalign;

   // Producer/consumer side of the unit.
   modport master (
      output in_valid, in_op, in_imm, in_data, in_addr, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag, out_misalign
   );

   // The extension unit itself.
   modport slave (
      input  in_valid, in_op, in_imm, in_data, in_addr, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag, out_misalign
   );
endinterface

// File: rtl/ext_pipe.sv
// Immediate / load-data extension unit with one registered stage and a 2-entry skid buffer.
// Latency: 1 clk from accept to out_valid.
// Backpressure: in_ready drops only when both entries are full; it depends on state alone, never on out_ready.
module ext_pipe #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int TAG_W  = 5
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     flush,
   ext_pipe_if.slave bus
);
   localparam int ADDR_W = $clog2(DATA_W / 8);

   localparam logic [2:0] OP_ZERO = 3'b000;
   localparam logic [2:0] OP_SIGN = 3'b001;
   localparam logic [2:0] OP_HIGH = 3'b010;
   localparam logic [2:0] OP_LB   = 3'b011;
   localparam logic [2:0] OP_LBU  = 3'b100;
   localparam logic [2:0] OP_LH   = 3'b101;
   localparam logic [2:0] OP_LHU  = 3'b110;
   localparam logic [2:0] OP_PASS = 3'b111;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [TAG_W-1:0]  tag;
      logic              misalign;
   } item_t;

   state_t            state;
   state_t            state_nxt;
   item_t             main_q;
   item_t             skid_q;
   item_t             new_item;
   logic              accept;
   logic              fire;
   logic              load_main_new;
   logic              load_main_skid;
   logic              load_skid;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [ADDR_W-1:0] half_addr;

   // Handshakes are derived from the state register only, so in_ready has no path from out_ready.
   assign accept = bus.in_valid && (state != TWO);
   assign fire   = (state != EMPTY) && bus.out_ready;

   // Extend the incoming item; bit 0 of the offset is ignored for halfword lane selection.
   always_comb begin
      half_addr         = bus.in_addr & ~ADDR_W'(1);
      byte_v            = 8'(bus.in_data >> {bus.in_addr, 3'b000});
      half_v            = 16'(bus.in_data >> {half_addr, 3'b000});
      new_item.result   = '0;
      new_item.tag      = bus.in_tag;
      new_item.misalign = ((bus.in_op == OP_LH) || (bus.in_op == OP_LHU)) && bus.in_addr[0];
      case (bus.in_op)
         OP_ZERO: new_item.result = DATA_W'(bus.in_imm);
         OP_SIGN: new_item.result = DATA_W'($signed(bus.in_imm));
         OP_HIGH: new_item.result = DATA_W'(bus.in_imm) << (DATA_W - IMM_W);
         OP_LB:   new_item.result = DATA_W'($signed(byte_v));
         OP_LBU:  new_item.result = DATA_W'(byte_v);
         OP_LH:   new_item.result = DATA_W'($signed(half_v));
         OP_LHU:  new_item.result = DATA_W'(half_v);
         OP_PASS: new_item.result = bus.in_data;
         default: new_item.result = '0;
      endcase
   end

   // Occupancy state register; flush behaves exactly like reset.
   always_ff @(posedge clk) begin
      if (reset || flush) state <= EMPTY;
      else                state <= state_nxt;
   end

   // Occupancy transitions.
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (accept) state_nxt = ONE;
         ONE:     if (accept && !fire) state_nxt = TWO;
                  else if (!accept && fire) state_nxt = EMPTY;
         TWO:     if (fire) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
   end

   // Handshake outputs and buffer load enables per occupancy.
   always_comb begin
      bus.in_ready   = (state != TWO);
      bus.out_valid  = (state != EMPTY);
      load_main_new  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY:   load_main_new = accept;
         ONE: begin
            load_main_new = accept && fire;
            load_skid     = accept && !fire;
         end
         TWO:     load_main_skid = fire;
         default: load_main_new = 1'b0;
      endcase
   end

   // Buffer entries; main holds still while stalled so the output stays stable.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_new)       main_q <= new_item;
         else if (load_main_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= new_item;
      end
   end

   assign bus.out_result   = main_q.result;
   assign bus.out_tag      = main_q.tag;
   assign bus.out_misalign = main_q.misalign;
endmodule
